// File: rtl/uart_print_pkg.sv
// Shared types and constants for the UART print controller: send FSM states,
// exit-report characters and the nibble-to-ASCII helper.
package uart_print_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_BUSY,
        ST_GAP
    } send_state_e;

    localparam logic [7:0] CH_E  = 8'h45;
    localparam logic [7:0] CH_EQ = 8'h3D;
    localparam logic [7:0] CH_NL = 8'h0A;

    localparam int unsigned RPT_LEN = 11;

    function automatic logic [7:0] nibble_to_hex(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/uart_print_fifo.sv
// Synchronous first-word-fall-through FIFO; pushes while full and pops while
// empty are ignored. Depth must be a power of two so the pointers wrap.
module uart_print_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == FULL_CNT);
    assign empty_o = (r_count == '0);
    assign level_o = r_count;
    assign rdata_o = r_mem[r_rptr];

    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_print_ctrl.sv
// Buffers core print bytes and feeds them to the UART via start/busy handshake.
// Define UART_PRINT_EXIT_REPORT_EN to append the "E=XXXXXXXX\n" exit report.
module uart_print_ctrl
    import uart_print_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          print_valid_i,
    input  logic [7:0]                    print_wdata_i,
    input  logic                          exit_valid_i,
    input  logic [31:0]                   exit_value_i,
    output logic                          tx_start_o,
    output logic [7:0]                    tx_data_o,
    input  logic                          tx_busy_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o,
    output logic                          done_o
);

    send_state_e r_state;
    logic        r_tx_start;
    logic [7:0]  r_tx_data;
    logic        r_done;
    logic        r_overflow;
    logic        r_exit_latched;

    logic        w_push_req;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_fifo_rdata;

    assign w_push_req = print_valid_i && !r_exit_latched;
    assign w_pop      = (r_state == ST_IDLE) && !w_empty;

    uart_print_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push_req),
        .wdata_i (print_wdata_i),
        .pop_i   (w_pop),
        .rdata_o (w_fifo_rdata),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (fifo_level_o)
    );

`ifdef UART_PRINT_EXIT_REPORT_EN
    logic [31:0] r_exit_value;
    logic [3:0]  r_rpt_idx;
    logic [2:0]  w_nib_sel;
    logic [3:0]  w_nib;
    logic [7:0]  w_rpt_byte;
    logic        w_rpt_go;

    assign w_rpt_go = (r_state == ST_IDLE) && w_empty && r_exit_latched
                      && (r_rpt_idx != 4'(RPT_LEN));

    // Report index 2..9 maps to nibble 7..0 of the exit value (MSB first).
    always_comb begin
        w_nib_sel  = 3'(4'd9 - r_rpt_idx);
        w_nib      = 4'(r_exit_value >> {w_nib_sel, 2'b00});
        w_rpt_byte = nibble_to_hex(w_nib);
        if (r_rpt_idx == 4'd0) begin
            w_rpt_byte = CH_E;
        end else if (r_rpt_idx == 4'd1) begin
            w_rpt_byte = CH_EQ;
        end else if (r_rpt_idx == 4'd10) begin
            w_rpt_byte = CH_NL;
        end
    end
`else
    logic w_unused_exit_value;
    assign w_unused_exit_value = ^exit_value_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_exit_latched <= 1'b0;
            r_overflow     <= 1'b0;
`ifdef UART_PRINT_EXIT_REPORT_EN
            r_exit_value   <= '0;
`endif
        end else begin
            if (exit_valid_i && !r_exit_latched) begin
                r_exit_latched <= 1'b1;
`ifdef UART_PRINT_EXIT_REPORT_EN
                r_exit_value   <= exit_value_i;
`endif
            end
            if (w_push_req && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_done     <= 1'b0;
`ifdef UART_PRINT_EXIT_REPORT_EN
            r_rpt_idx  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_tx_data  <= w_fifo_rdata;
                        r_tx_start <= 1'b1;
                        r_state    <= ST_START;
                    end
`ifdef UART_PRINT_EXIT_REPORT_EN
                    else if (w_rpt_go) begin
                        r_tx_data  <= w_rpt_byte;
                        r_rpt_idx  <= r_rpt_idx + 4'd1;
                        r_tx_start <= 1'b1;
                        r_state    <= ST_START;
                    end
`else
                    else if (r_exit_latched) begin
                        r_done <= 1'b1;
                    end
`endif
                end
                ST_START: begin
                    if (tx_busy_i) begin
                        r_tx_start <= 1'b0;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!tx_busy_i) begin
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
`ifdef UART_PRINT_EXIT_REPORT_EN
                    if (r_rpt_idx == 4'(RPT_LEN)) begin
                        r_done <= 1'b1;
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx_start_o = r_tx_start;
    assign tx_data_o  = r_tx_data;
    assign overflow_o = r_overflow;
    assign done_o     = r_done;

endmodule

// File: doc/uart_print_ctrl.md
# uart_print_ctrl

Sequencer and arbiter between the core subsystem's print/exit outputs and the 8-bit UART transmitter on the FPGA implementation top. It buffers print bytes in a small FIFO, hands them one at a time to the UART using its start/busy handshake, and drops bytes only when the FIFO is full. After the core signals exit, the block drains pending prints and then, optionally, sends a fixed-format exit report built from the exit value.

## Interface
- FIFO_DEPTH, 16: print FIFO entries; power of two, at least 2.
- clk_i  in  1  system clock (the divided core clock).
- rst_ni  in  1  reset, asynchronous, active-low.
- print_valid_i  in  1  one-cycle print strobe from the subsystem.
- print_wdata_i  in  8  print byte, taken from print_wdata[7:0].
- exit_valid_i  in  1  exit strobe from the subsystem.
- exit_value_i  in  32  exit code, sampled when exit_valid_i is high.
- tx_start_o  out  1  UART start request.
- tx_data_o  out  8  byte presented to the UART.
- tx_busy_i  in  1  UART transmitting.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow_o  out  1  sticky flag: a print byte was dropped.
- done_o  out  1  exit latched and all output has been sent.

## Operation
- Push: print_valid_i=1, exit not latched, FIFO not full → byte written. Full (registered count = FIFO_DEPTH) → byte dropped, overflow_o set until reset. A push and a pop in the same cycle while full still drops the byte.
- Exit latch: the first exit_valid_i=1 captures exit_value_i. Later exit strobes are ignored. Print strobes after the latch are discarded silently and do not set overflow_o.
- Source arbitration: the FIFO has priority. The exit report starts only when the FIFO is empty and the FSM is in IDLE.
- Exit report: 11 bytes, in this order:
  - 'E' (0x45), '=' (0x3D);
  - 8 uppercase hex digits of exit_value, MSB nibble first;
  - '\n' (0x0A).
- Send FSM states:
  - IDLE: select the next byte, register it into tx_data_o, go to START.
  - START: hold tx_start_o=1 until tx_busy_i=1, then go to BUSY.
  - BUSY: wait until tx_busy_i=0, then go to GAP.
  - GAP: one idle cycle, then go to IDLE.
- tx_data_o stays stable from START until the end of BUSY.
- done_o goes high in the GAP→IDLE transition after the last report byte. It then stays high until reset.

## Timing
- Reset values: tx_start_o=0, tx_data_o=0, fifo_level_o=0, overflow_o=0, done_o=0. FSM=IDLE, exit not latched, report index=0.
- Latency: push at cycle N with FIFO empty and FSM in IDLE → FIFO non-empty at N+1 → tx_start_o=1 at N+2.
- Pop happens on the IDLE→START transition. fifo_level_o updates in the following cycle.
- Minimum spacing between tx_start_o rising edges: START (1 cycle or more) + BUSY (1 cycle or more) + GAP (1) + IDLE (1).
- Reset asserted mid-operation: all state clears immediately. The UART may finish its current frame on its own.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. The count is one bit wider.

## Configuration
- UART_PRINT_EXIT_REPORT_EN defined: the exit report is generated as described above.
- Not defined: no report logic is built. The exit latch and the print-discard-after-exit rule remain. done_o=1 once exit is latched, the FIFO is empty and the FSM is in IDLE.

## Structure
- uart_print_pkg holds:
  - the send FSM state enum;
  - byte constants 'E', '=', '\n';
  - a nibble-to-ASCII-hex function;
  - the report length constant (11).
- Sub-module uart_print_fifo: synchronous FIFO with push, pop, full, empty and level, parameterised by depth and width.

## Test plan
- Single print of 0x41 with the UART model busy for 10 cycles → tx_start_o at N+2, tx_data_o=0x41, fifo_level_o returns to 0, overflow_o=0.
- Burst of 20 back-to-back prints (0x00..0x13), FIFO_DEPTH=16, UART busy for 100 cycles → exactly 17 bytes sent (1 in flight plus 16 buffered), in order, and overflow_o=1.
- Exit with exit_value_i=0x0000002A while 3 prints are pending → the 3 prints go out first, then 45 3D 30 30 30 30 30 30 32 41 0A, then done_o=1.
- Prints and a second exit strobe issued after exit → nothing extra is transmitted and overflow_o is unchanged.
- Reset pulse during BUSY with 5 bytes queued → all outputs return to reset values and no further tx_start_o until a new push.
- Build without UART_PRINT_EXIT_REPORT_EN, then exit → no report bytes, and done_o=1 once the FIFO drains.
